// File: rtl/hex_keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package hex_keypad_scanner_pkg;

  localparam int unsigned MAT_N  = 4;  // rows and columns in the matrix
  localparam int unsigned IDX_W  = 2;  // width of a row or column index
  localparam int unsigned CODE_W = 4;  // key code width

  // Scanner states: idle, four column strobes, key held
  typedef enum logic [2:0] {
    S_0 = 3'd0,
    S_1 = 3'd1,
    S_2 = 3'd2,
    S_3 = 3'd3,
    S_4 = 3'd4,
    S_5 = 3'd5
  } state_t;

  // Column drive patterns
  localparam logic [MAT_N-1:0] COL_ALL = 4'b1111;
  localparam logic [MAT_N-1:0] COL_0   = 4'b0001;
  localparam logic [MAT_N-1:0] COL_1   = 4'b0010;
  localparam logic [MAT_N-1:0] COL_2   = 4'b0100;
  localparam logic [MAT_N-1:0] COL_3   = 4'b1000;

endpackage

// File: rtl/hex_key_encoder.sv
// Maps the sampled row lines and the one-hot column drive to a key code.
// Multi-row presses resolve to the lowest active row.
module hex_key_encoder
  import hex_keypad_scanner_pkg::*;
(
  input  logic [MAT_N-1:0]  row,
  input  logic [MAT_N-1:0]  col,
  output logic [CODE_W-1:0] code
);

  logic [IDX_W-1:0] row_idx;
  logic [IDX_W-1:0] col_idx;

  // Lowest-set-bit priority on row; scan from the top so lower rows win
  always_comb begin
    row_idx = '0;
    for (int i = MAT_N - 1; i >= 0; i--) begin
      if (row[i]) row_idx = IDX_W'(i);
    end
  end

  // One-hot column to index; non one-hot drive yields zero
  always_comb begin
    col_idx = '0;
    case (col)
      COL_0:   col_idx = 2'd0;
      COL_1:   col_idx = 2'd1;
      COL_2:   col_idx = 2'd2;
      COL_3:   col_idx = 2'd3;
      default: col_idx = '0;
    endcase
  end

  assign code = {row_idx, col_idx};

endmodule

// File: rtl/hex_keypad_scanner.sv
// Column-scanning controller for a 4x4 hex keypad: strobes columns one at a
// time once any row is active and reports the identified key for one cycle.
module hex_keypad_scanner
  import hex_keypad_scanner_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [MAT_N-1:0]  row,
  input  logic              s_row,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [MAT_N-1:0]  col
);

  state_t            state_q;
  state_t            state_d;
  logic [CODE_W-1:0] enc_code;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_0;
    else     state_q <= state_d;
  end

  // Next state, column drive and detection strobe
  always_comb begin
    state_d = S_0;
    col     = COL_ALL;
    valid   = 1'b0;
    case (state_q)
      S_0: state_d = s_row ? S_1 : S_0;
      S_1: begin
        col     = COL_0;
        valid   = |row;
        state_d = (|row) ? S_5 : S_2;
      end
      S_2: begin
        col     = COL_1;
        valid   = |row;
        state_d = (|row) ? S_5 : S_3;
      end
      S_3: begin
        col     = COL_2;
        valid   = |row;
        state_d = (|row) ? S_5 : S_4;
      end
      S_4: begin
        col     = COL_3;
        valid   = |row;
        state_d = (|row) ? S_5 : S_0;
      end
      S_5: state_d = s_row ? S_5 : S_0;
      default: state_d = S_0;
    endcase
  end

  hex_key_encoder u_enc (
    .row  (row),
    .col  (col),
    .code (enc_code)
  );

  // Code is only meaningful while a key is being detected
  assign code = valid ? enc_code : '0;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner with a behavioural keypad model.
module tb_hex_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic       s_row = 1'b0;
  logic       valid;
  logic [3:0] code;
  logic [3:0] col;

  // Keypad model: pressed rows conduct to column key_c when it is driven
  logic       key_on   = 1'b0;
  logic [3:0] key_mask = 4'b0;
  logic [1:0] key_c    = 2'd0;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc       = 0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  hex_keypad_scanner dut (
    .clk   (clk),
    .rst   (rst),
    .row   (row),
    .s_row (s_row),
    .valid (valid),
    .code  (code),
    .col   (col)
  );

  always #5 clk = ~clk;

  always_comb row = (key_on && col[key_c]) ? key_mask : 4'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every detection must match the next expected key and latency
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("code", int'(code), int'(e.code));
          check("latency_cycle", cyc, e.cyc);
        end
      end else begin
        check("code_zero_when_idle", int'(code), 0);
      end
    end
  end

  // Press a key (rows in mask, column c), hold, release, confirm idle
  task automatic press(input int mask, input int c, input int hold);
    int r;
    exp_t e;
    @(posedge clk); #1;
    r = 0;
    for (int i = 3; i >= 0; i--) if (mask[i]) r = i;
    key_mask = 4'(mask);
    key_c    = 2'(c);
    key_on   = 1'b1;
    s_row    = 1'b1;
    e.code   = 4'(4 * r + c);
    e.cyc    = cyc + c + 1;
    q.push_back(e);
    repeat (hold) @(posedge clk);
    #1;
    check("pulse_consumed", q.size(), 0);
    q.delete();
    check("col_while_held", int'(col), 15);
    key_on = 1'b0;
    s_row  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("col_after_release", int'(col), 15);
  endtask

  initial begin
    int exp_cols[5];
    exp_cols = '{1, 2, 4, 8, 15};

    // Reset state
    #1;
    check("rst_col", int'(col), 15);
    check("rst_valid", int'(valid), 0);
    check("rst_code", int'(code), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Corner keys, then held key with re-press
    press(4'b0001, 0, 6);
    press(4'b1000, 3, 8);
    press(4'b0010, 2, 20);
    press(4'b0010, 2, 6);

    // Bounce: s_row high with no conducting row
    @(posedge clk); #1;
    s_row = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bounce_col", int'(col), exp_cols[i]);
    end
    repeat (6) @(posedge clk);
    #1 s_row = 1'b0;
    repeat (6) @(posedge clk);

    // Key released mid-scan before its column is strobed
    @(posedge clk); #1;
    key_mask = 4'b0100; key_c = 2'd3; key_on = 1'b1; s_row = 1'b1;
    repeat (2) @(posedge clk);
    #1 key_on = 1'b0; s_row = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("midscan_release_idle", int'(col), 15);

    // Async reset mid-scan in S_2
    @(posedge clk); #1;
    key_mask = 4'b0001; key_c = 2'd3; key_on = 1'b1; s_row = 1'b1;
    repeat (2) @(posedge clk);
    #2 check("pre_reset_col", int'(col), 2);
    rst = 1'b1;
    #1;
    check("async_rst_col", int'(col), 15);
    check("async_rst_valid", int'(valid), 0);
    check("async_rst_code", int'(code), 0);
    key_on = 1'b0; s_row = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // All 16 keys
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        press(1 << r, c, 5 + int'($urandom_range(0, 4)));

    // Random multi-row presses resolve to the lowest row
    for (int n = 0; n < 24; n++)
      press(int'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
            5 + int'($urandom_range(0, 6)));

    repeat (4) @(posedge clk);
    #1 check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
